gen_reg_file: RTL and testbench

- Parametrised successor to the fixed 8-bit register file: NREGS general registers of WIDTH bits each.
- Per-cycle function select applied to a register-enable mask; two independent asynchronous read ports.
- Adds shift, register-to-register copy, selectable saturate/wrap arithmetic and an overflow pulse flag.
- Sits between MuxA/ALU output and ALU A/B inputs in the next-generation ALU system.

---
 rtl/gen_reg_file_if.sv | 31 +++
 rtl/gen_reg_file.sv | 136 +++++++++++++
 tb/tb_gen_reg_file.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/gen_reg_file_if.sv
// Bus bundle for gen_reg_file: function/enable/select inputs and read/flag outputs.
//   master : driver side (ALU system / testbench) - drives selects and load data
//   slave  : register file side - drives O1/O2/OVF/Z1
// clk/rst are kept as plain module ports.
interface gen_reg_file_if #(
  parameter int WIDTH = 8,
  parameter int NREGS = 8
);
  localparam int SW = $clog2(NREGS);

  logic [2:0]       FunSel;
  logic [NREGS-1:0] RegSel;
  logic [SW-1:0]    SrcSel;
  logic [WIDTH-1:0] I;
  logic [SW-1:0]    O1Sel;
  logic [SW-1:0]    O2Sel;
  logic [WIDTH-1:0] O1;
  logic [WIDTH-1:0] O2;
  logic             OVF;
  logic             Z1;

  modport master (
    output FunSel, RegSel, SrcSel, I, O1Sel, O2Sel,
    input  O1, O2, OVF, Z1
  );

  modport slave (
    input  FunSel, RegSel, SrcSel, I, O1Sel, O2Sel,
    output O1, O2, OVF, Z1
  );
endinterface

// File: rtl/gen_reg_file.sv
// gen_reg_file: NREGS x WIDTH register file with a per-cycle function applied
// to every register enabled in RegSel, two combinational read ports and a
// registered one-cycle overflow pulse.
//   CLK  : rising-edge clock
//   RST  : asynchronous active-high reset, loads RESET_VAL, clears OVF
//   bus  : gen_reg_file_if.slave (FunSel, RegSel, SrcSel, I, O1Sel, O2Sel -> O1, O2, OVF, Z1)
// FunSel: 000 hold, 001 clear, 010 load I, 011 inc, 100 dec, 101 shl, 110 shr,
//         111 copy from SrcSel (pre-edge value).
// Optional: define GEN_REG_FILE_BYPASS_EN to forward I to O1/O2 (and Z1)
// combinationally when a load targets the register being read.

// One register: next-value / overflow-event logic plus the storage flop.
module gen_reg_file_cell #(
  parameter int               WIDTH     = 8,
  parameter int               SATURATE  = 0,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [2:0]       fun,
  input  logic [WIDTH-1:0] ld,
  input  logic [WIDTH-1:0] src,
  output logic [WIDTH-1:0] q,
  output logic             evt
);
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic [WIDTH-1:0] nxt;

  always_comb begin
    nxt = q;
    evt = 1'b0;
    case (fun)
      3'b001: nxt = '0;
      3'b010: nxt = ld;
      3'b011: begin
        if (&q) begin
          evt = 1'b1;
          nxt = (SATURATE != 0) ? q : '0;
        end else begin
          nxt = q + ONE;
        end
      end
      3'b100: begin
        if (q == '0) begin
          evt = 1'b1;
          nxt = (SATURATE != 0) ? q : '1;
        end else begin
          nxt = q - ONE;
        end
      end
      3'b101: begin
        evt = q[WIDTH-1];
        nxt = {q[WIDTH-2:0], 1'b0};
      end
      3'b110: begin
        evt = q[0];
        nxt = {1'b0, q[WIDTH-1:1]};
      end
      3'b111: nxt = src;
      default: nxt = q;
    endcase
    // disabled registers hold and never report an event
    if (!en) begin
      nxt = q;
      evt = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) q <= RESET_VAL;
    else     q <= nxt;
  end
endmodule

module gen_reg_file #(
  parameter int          WIDTH     = 8,
  parameter int          NREGS     = 8,
  parameter int          SATURATE  = 0,
  parameter logic [31:0] RESET_VAL = '0
) (
  input  logic           CLK,
  input  logic           RST,
  gen_reg_file_if.slave  bus
);
  logic [NREGS-1:0][WIDTH-1:0] regs;
  logic [NREGS-1:0]            evt;
  logic [WIDTH-1:0]            src;
  logic [WIDTH-1:0]            o1;
  logic [WIDTH-1:0]            o2;
  logic                        ovf;

  // copy source taken from pre-edge contents, so an enabled source rewrites itself
  assign src = regs[bus.SrcSel];

  for (genvar k = 0; k < NREGS; k++) begin : g_reg
    gen_reg_file_cell #(
      .WIDTH    (WIDTH),
      .SATURATE (SATURATE),
      .RESET_VAL(RESET_VAL[WIDTH-1:0])
    ) u_cell (
      .clk(CLK),
      .rst(RST),
      .en (bus.RegSel[k]),
      .fun(bus.FunSel),
      .ld (bus.I),
      .src(src),
      .q  (regs[k]),
      .evt(evt[k])
    );
  end

  // one-cycle pulse: reflects only the most recent edge
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) ovf <= 1'b0;
    else     ovf <= |evt;
  end

`ifdef GEN_REG_FILE_BYPASS_EN
  always_comb begin
    o1 = regs[bus.O1Sel];
    o2 = regs[bus.O2Sel];
    if (bus.FunSel == 3'b010 && bus.RegSel[bus.O1Sel]) o1 = bus.I;
    if (bus.FunSel == 3'b010 && bus.RegSel[bus.O2Sel]) o2 = bus.I;
  end
`else
  assign o1 = regs[bus.O1Sel];
  assign o2 = regs[bus.O2Sel];
`endif

  assign bus.O1  = o1;
  assign bus.O2  = o2;
  assign bus.Z1  = (o1 == '0);
  assign bus.OVF = ovf;
endmodule

// File: tb/tb_gen_reg_file.sv
// Directed bench: dut_a (wrap, RESET_VAL 5A), dut_b (saturate, RESET_VAL 5A)
// share stimulus; dut_c is the 16x16 parameter sweep.
module tb_gen_reg_file;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_chk = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  gen_reg_file_if #(.WIDTH(8),  .NREGS(8))  a_if();
  gen_reg_file_if #(.WIDTH(8),  .NREGS(8))  b_if();
  gen_reg_file_if #(.WIDTH(16), .NREGS(16)) c_if();

  gen_reg_file #(.WIDTH(8), .NREGS(8), .SATURATE(0), .RESET_VAL(32'h5A))
    dut_a (.CLK(clk), .RST(rst), .bus(a_if));
  gen_reg_file #(.WIDTH(8), .NREGS(8), .SATURATE(1), .RESET_VAL(32'h5A))
    dut_b (.CLK(clk), .RST(rst), .bus(b_if));
  gen_reg_file #(.WIDTH(16), .NREGS(16), .SATURATE(0), .RESET_VAL(32'h0))
    dut_c (.CLK(clk), .RST(rst), .bus(c_if));

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // same op on a and b
  task automatic drv(input logic [2:0] fun, input logic [7:0] sel, input logic [7:0] d);
    a_if.FunSel = fun; a_if.RegSel = sel; a_if.I = d;
    b_if.FunSel = fun; b_if.RegSel = sel; b_if.I = d;
  endtask

  task automatic rd(input string tag, input logic [2:0] idx,
                    input logic [7:0] ea, input logic [7:0] eb);
    a_if.O1Sel = idx; b_if.O1Sel = idx;
    #1;
    chk({tag, "_a"}, 32'(a_if.O1), 32'(ea));
    chk({tag, "_b"}, 32'(b_if.O1), 32'(eb));
  endtask

  task automatic ovf(input string tag, input logic e);
    chk({tag, "_ovf_a"}, 32'(a_if.OVF), 32'(e));
    chk({tag, "_ovf_b"}, 32'(b_if.OVF), 32'(e));
  endtask

  initial begin
    drv(3'b000, 8'h00, 8'h00);
    a_if.SrcSel = '0; a_if.O1Sel = '0; a_if.O2Sel = '0;
    b_if.SrcSel = '0; b_if.O1Sel = '0; b_if.O2Sel = '0;
    c_if.FunSel = 3'b000; c_if.RegSel = '0; c_if.SrcSel = '0;
    c_if.I = '0; c_if.O1Sel = 4'd15; c_if.O2Sel = '0;

    // asynchronous reset mid-cycle, no clock edge yet
    #2 rst = 1'b1;
    #1;
    chk("rst_o1", 32'(a_if.O1), 32'h5A);
    chk("rst_o2", 32'(a_if.O2), 32'h5A);
    chk("rst_z1", 32'(a_if.Z1), 32'h0);
    chk("rst_ovf", 32'(a_if.OVF), 32'h0);
    chk("rst_c_z1", 32'(c_if.Z1), 32'h1);
    step(); step();
    rst = 1'b0;

    // load R0,R2
    drv(3'b010, 8'b0000_0101, 8'hAA);
    step();
    drv(3'b000, 8'h00, 8'h00);
    ovf("load", 1'b0);
    rd("ld_r0", 3'd0, 8'hAA, 8'hAA);
    rd("ld_r1", 3'd1, 8'h5A, 8'h5A);
    rd("ld_r2", 3'd2, 8'hAA, 8'hAA);
    a_if.O2Sel = 3'd2; #1;
    chk("same_sel_o2", 32'(a_if.O2), 32'hAA);

    // increment from all-ones
    drv(3'b010, 8'h08, 8'hFF); step();
    drv(3'b011, 8'h08, 8'h00); step();
    ovf("inc", 1'b1);
    rd("inc_r3", 3'd3, 8'h00, 8'hFF);
    // disabled increment: no change, pulse drops
    drv(3'b011, 8'h00, 8'h00); step();
    ovf("idle", 1'b0);
    rd("idle_r3", 3'd3, 8'h00, 8'hFF);

    // decrement from zero
    drv(3'b001, 8'h08, 8'h00); step();
    ovf("clr", 1'b0);
    drv(3'b100, 8'h08, 8'h00); step();
    ovf("dec", 1'b1);
    rd("dec_r3", 3'd3, 8'hFF, 8'h00);

    // shifts
    drv(3'b010, 8'h02, 8'h81); step();
    drv(3'b101, 8'h02, 8'h00); step();
    ovf("shl", 1'b1);
    rd("shl_r1", 3'd1, 8'h02, 8'h02);
    drv(3'b110, 8'h02, 8'h00); step();
    ovf("shr1", 1'b0);
    rd("shr1_r1", 3'd1, 8'h01, 8'h01);
    step();
    ovf("shr2", 1'b1);
    rd("shr2_r1", 3'd1, 8'h00, 8'h00);
    chk("shr2_z1", 32'(a_if.Z1), 32'h1);

    // copy R4 into R0, R7 (R4 itself enabled)
    drv(3'b010, 8'h10, 8'h3C); step();
    a_if.SrcSel = 3'd4; b_if.SrcSel = 3'd4;
    drv(3'b111, 8'b1001_0001, 8'h00); step();
    drv(3'b000, 8'h00, 8'h00);
    rd("cp_r0", 3'd0, 8'h3C, 8'h3C);
    rd("cp_r7", 3'd7, 8'h3C, 8'h3C);
    rd("cp_r4", 3'd4, 8'h3C, 8'h3C);
    rd("cp_r1", 3'd1, 8'h00, 8'h00);

    // reset held across an edge carrying a full load
    drv(3'b010, 8'hFF, 8'h11);
    #3 rst = 1'b1;
    step();
    drv(3'b000, 8'h00, 8'h00);
    #2 rst = 1'b0;
    rd("rstld_r0", 3'd0, 8'h5A, 8'h5A);
    rd("rstld_r5", 3'd5, 8'h5A, 8'h5A);

    // full clear
    drv(3'b001, 8'hFF, 8'h00); step();
    drv(3'b000, 8'h00, 8'h00);
    rd("fclr_r0", 3'd0, 8'h00, 8'h00);
    rd("fclr_r7", 3'd7, 8'h00, 8'h00);
    chk("fclr_z1", 32'(a_if.Z1), 32'h1);

    // bypass on load to R2 (R2 currently 0)
    a_if.O1Sel = 3'd2; a_if.O2Sel = 3'd2;
    drv(3'b010, 8'h04, 8'h77);
    #1;
`ifdef GEN_REG_FILE_BYPASS_EN
    chk("byp_o1", 32'(a_if.O1), 32'h77);
    chk("byp_o2", 32'(a_if.O2), 32'h77);
    chk("byp_z1", 32'(a_if.Z1), 32'h0);
`else
    chk("byp_o1", 32'(a_if.O1), 32'h00);
    chk("byp_o2", 32'(a_if.O2), 32'h00);
    chk("byp_z1", 32'(a_if.Z1), 32'h1);
`endif
    step();
    drv(3'b000, 8'h00, 8'h00);
    #1;
    chk("post_o1", 32'(a_if.O1), 32'h77);

    // 16x16 sweep: R15 wraps
    c_if.FunSel = 3'b010; c_if.RegSel = 16'h8000; c_if.I = 16'hFFFF; step();
    chk("c_ld", 32'(c_if.O1), 32'hFFFF);
    c_if.FunSel = 3'b011; step();
    c_if.FunSel = 3'b000; c_if.RegSel = '0;
    chk("c_inc", 32'(c_if.O1), 32'h0000);
    chk("c_ovf", 32'(c_if.OVF), 32'h1);
    step();
    chk("c_ovf_drop", 32'(c_if.OVF), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
